// File: rtl/mod_neuron_worker_pkg.sv
// -----------------------------------------------------------------------------
// mod_neuron_worker_pkg
// Shared definitions for the neuron worker lane:
//   - FSM state encodings (plain 3-bit constants so existing decoders that
//     match on the raw values keep working)
//   - helpers that derive the signed saturation bounds from a data width
// No ports; imported by mod_neuron_worker and mod_mac_sat.
// -----------------------------------------------------------------------------
package mod_neuron_worker_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] RESULT = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // Largest value representable in a w-bit two's complement word.
  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/mod_mac_sat.sv
// -----------------------------------------------------------------------------
// mod_mac_sat
// Signed multiply-accumulate with synchronous clear, followed by the
// threshold compare and shift/saturate output stage.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          clears accumulator and both result registers (highest priority)
//   acc_en       acc += a * b (full-precision signed product)
//   res_en       registers spike and the saturated, shifted accumulator
//   a, b         signed DATA_W operands
//   thresh       signed ACC_W firing threshold
//   sat_out      registered saturated result
//   spike        registered (acc >= thresh)
// -----------------------------------------------------------------------------
module mod_mac_sat
  import mod_neuron_worker_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     acc_en,
  input  logic                     res_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  thresh,
  output logic signed [DATA_W-1:0] sat_out,
  output logic                     spike
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] HI_A = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] LO_A = ACC_W'(sat_lo(DATA_W));

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat_val;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     spike_q, spike_d;

  // Operands are widened before the multiply so the product is exact.
  assign a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted  = acc_q >>> SHIFT;

  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (shifted > HI_A) begin
      sat_val = HI_A[DATA_W-1:0];
    end else if (shifted < LO_A) begin
      sat_val = LO_A[DATA_W-1:0];
    end
  end

  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    spike_d = spike_q;
    if (clr) begin
      acc_d   = '0;
      out_d   = '0;
      spike_d = 1'b0;
    end else begin
      if (acc_en) begin
        acc_d = acc_q + prod_ext;
      end
      if (res_en) begin
        out_d   = sat_val;
        spike_d = (acc_q >= thresh);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      out_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      out_q   <= out_d;
      spike_q <= spike_d;
    end
  end

  assign sat_out = out_q;
  assign spike   = spike_q;

endmodule

// File: rtl/mod_neuron_worker.sv
// -----------------------------------------------------------------------------
// mod_neuron_worker
// One neuron lane. On a resetEverything pulse it reads NUM_INPUTS
// (input, weight) pairs from synapse memory, accumulates their signed
// products, then registers a threshold spike and a shifted/saturated output
// and raises finishedOp (a level) until critical drops or a new op starts.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   resetEverything     clear/start pulse (priority over everything)
//   critical            operation window; low aborts the op / ends DONE
//   thresholdIn         signed threshold, latched on resetEverything
//   memRdEn, memAddr    synapse read strobe and address
//   inputData           signed sample, valid the cycle after memRdEn
//   weightData          signed weight, valid the cycle after memRdEn
//   neuronOut, spike    registered results
//   finishedOp          result valid level
// -----------------------------------------------------------------------------
module mod_neuron_worker
  import mod_neuron_worker_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int SHIFT      = 4,
  parameter int ACC_W      = 2 * DATA_W + ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resetEverything,
  input  logic              critical,
  input  logic [ACC_W-1:0]  thresholdIn,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] inputData,
  input  logic [DATA_W-1:0] weightData,
  output logic [DATA_W-1:0] neuronOut,
  output logic              spike,
  output logic              finishedOp
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              data_vld_q, data_vld_d;
  logic [ACC_W-1:0]  thr_q, thr_d;
  logic              fin_q, fin_d;

  logic              mac_clr;
  logic              mac_acc_en;
  logic              mac_res_en;
  logic [DATA_W-1:0] mac_out;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    thr_d      = thr_q;
    fin_d      = fin_q;
    // Memory returns data one cycle after the strobe.
    data_vld_d = rd_en_q;
    mac_clr    = 1'b0;
    mac_acc_en = 1'b0;
    mac_res_en = 1'b0;

    if (resetEverything) begin
      state_d    = FETCH;
      addr_d     = '0;
      rd_en_d    = 1'b1;
      thr_d      = thresholdIn;
      fin_d      = 1'b0;
      mac_clr    = 1'b1;
      // The read issued this cycle belongs to the old op; drop its data.
      data_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Memory data is ignored; wait for the next start pulse.
        end
        FETCH: begin
          if (!critical) begin
            state_d = IDLE;
          end else begin
            mac_acc_en = data_vld_q;
            if (addr_q == LAST_ADDR) begin
              state_d = DRAIN;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              rd_en_d = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!critical) begin
            state_d = IDLE;
          end else begin
            mac_acc_en = data_vld_q;
            state_d    = RESULT;
          end
        end
        RESULT: begin
          if (!critical) begin
            state_d = IDLE;
          end else begin
            mac_res_en = 1'b1;
            fin_d      = 1'b1;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (!critical) begin
            state_d = IDLE;
            fin_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          fin_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      data_vld_q <= 1'b0;
      thr_q      <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      data_vld_q <= data_vld_d;
      thr_q      <= thr_d;
      fin_q      <= fin_d;
    end
  end

  mod_mac_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .acc_en  (mac_acc_en),
    .res_en  (mac_res_en),
    .a       (inputData),
    .b       (weightData),
    .thresh  (thr_q),
    .sat_out (mac_out),
    .spike   (spike)
  );

  assign memRdEn    = rd_en_q;
  assign memAddr    = addr_q;
  assign neuronOut  = mac_out;
  assign finishedOp = fin_q;

endmodule

// File: tb/tb_mod_neuron_worker.sv
// -----------------------------------------------------------------------------
// tb_mod_neuron_worker
// Directed and randomized operations on a 4-synapse lane with SHIFT=4.
// A synapse memory responder returns data one cycle after each read strobe
// and random junk otherwise; expected results come from a plain arithmetic
// dot-product model.
// -----------------------------------------------------------------------------
module tb_mod_neuron_worker;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int SH   = 4;
  localparam int ACCW = 2 * DW + AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            resetEverything;
  logic            critical;
  logic [ACCW-1:0] thresholdIn;
  logic            memRdEn;
  logic [AW-1:0]   memAddr;
  logic [DW-1:0]   inputData;
  logic [DW-1:0]   weightData;
  logic [DW-1:0]   neuronOut;
  logic            spike;
  logic            finishedOp;

  logic signed [DW-1:0] mem_in [16];
  logic signed [DW-1:0] mem_w  [16];

  int     total = 0;
  int     bad   = 0;
  longint exp_acc, exp_out, exp_spk;

  always #5 clk = ~clk;

  mod_neuron_worker #(
    .NUM_INPUTS (N),
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .SHIFT      (SH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .resetEverything (resetEverything),
    .critical        (critical),
    .thresholdIn     (thresholdIn),
    .memRdEn         (memRdEn),
    .memAddr         (memAddr),
    .inputData       (inputData),
    .weightData      (weightData),
    .neuronOut       (neuronOut),
    .spike           (spike),
    .finishedOp      (finishedOp)
  );

  // Synapse memory: data for a strobe appears in the following cycle.
  always @(posedge clk) begin
    if (memRdEn) begin
      inputData  <= mem_in[memAddr];
      weightData <= mem_w[memAddr];
    end else begin
      inputData  <= DW'($urandom);
      weightData <= DW'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Dot product of the first N synapses, then shift, saturate, compare.
  task automatic model(input longint thr);
    longint sh;
    exp_acc = 0;
    for (int i = 0; i < N; i++) exp_acc += longint'(mem_in[i]) * longint'(mem_w[i]);
    sh = exp_acc >>> SH;
    if (sh > 127) exp_out = 127;
    else if (sh < -128) exp_out = -128;
    else exp_out = sh;
    exp_spk = (exp_acc >= thr) ? 1 : 0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_rd"}, memRdEn, 0);
    chk({nm, "_fin"}, finishedOp, 0);
  endtask

  // Full operation with cycle-exact checks; returns in DONE, critical high.
  task automatic run_op(input longint thr, input string nm);
    logic [63:0] thr_bits;
    model(thr);
    thr_bits        = thr;
    thresholdIn     = thr_bits[ACCW-1:0];
    critical        = 1'b1;
    resetEverything = 1'b1;
    tick();
    resetEverything = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk({nm, "_fetch_rd"}, memRdEn, 1);
      chk({nm, "_fetch_addr"}, memAddr, i);
      chk({nm, "_fetch_fin"}, finishedOp, 0);
      if (i == 0) begin
        chk({nm, "_clr_out"}, $signed(neuronOut), 0);
        chk({nm, "_clr_spike"}, spike, 0);
      end
      tick();
    end
    chk_idle_outputs({nm, "_drain"});
    tick();
    chk_idle_outputs({nm, "_result"});
    tick();
    chk({nm, "_done_fin"}, finishedOp, 1);
    chk({nm, "_out"}, $signed(neuronOut), exp_out);
    chk({nm, "_spike"}, spike, exp_spk);
    tick();
    chk({nm, "_hold_fin"}, finishedOp, 1);
    chk({nm, "_hold_out"}, $signed(neuronOut), exp_out);
    chk({nm, "_hold_rd"}, memRdEn, 0);
    $display("op %s: acc=%0d thr=%0d out=%0d spike=%0d", nm, exp_acc, thr,
             $signed(neuronOut), spike);
  endtask

  initial begin
    logic signed [DW-1:0] vals [4];
    longint thr;

    rst_n           = 1'b0;
    resetEverything = 1'b0;
    critical        = 1'b0;
    thresholdIn     = '0;
    for (int i = 0; i < 16; i++) begin
      mem_in[i] = '0;
      mem_w[i]  = '0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_rd", memRdEn, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_out", neuronOut, 0);
    chk("rst_spike", spike, 0);
    chk("rst_fin", finishedOp, 0);
    rst_n    = 1'b1;
    critical = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle_outputs("idle_wait");
    end

    // Basic op: 10+20+30+40 = 100, >>>4 = 6
    vals = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
    for (int i = 0; i < N; i++) begin
      mem_in[i] = vals[i];
      mem_w[i]  = 8'sd1;
    end
    run_op(10, "basic");
    // Threshold boundary: equal fires, one above does not
    run_op(100, "thr_eq");
    run_op(101, "thr_above");

    // Negative saturation: 4 * (-128*127) = -65024
    for (int i = 0; i < N; i++) begin
      mem_in[i] = -8'sd128;
      mem_w[i]  = 8'sd127;
    end
    run_op(0, "neg_sat");
    // Positive saturation: 4 * 16384 = 65536
    for (int i = 0; i < N; i++) mem_w[i] = -8'sd128;
    run_op(0, "pos_sat");

    // critical low in DONE: finishedOp drops, results hold
    critical = 1'b0;
    tick();
    chk("done_drop_fin", finishedOp, 0);
    chk("done_drop_out", $signed(neuronOut), exp_out);
    chk("done_drop_spike", spike, exp_spk);
    critical = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle_outputs("done_drop_idle");
    end

    // Abort mid-fetch: critical low in cycle 2
    for (int i = 0; i < N; i++) begin
      mem_in[i] = DW'($urandom);
      mem_w[i]  = DW'($urandom);
    end
    thresholdIn     = '0;
    resetEverything = 1'b1;
    tick();
    resetEverything = 1'b0;
    tick();
    critical = 1'b0;
    tick();
    chk("abort_rd", memRdEn, 0);
    critical = 1'b1;
    for (int c = 0; c < 2 * N + 4; c++) begin
      tick();
      chk_idle_outputs("abort_idle");
      chk("abort_out", neuronOut, 0);
    end
    $display("op abort: fetch abandoned in cycle 2");

    // Restart mid-operation: second pulse in cycle 3
    thresholdIn     = ACCW'(999);
    resetEverything = 1'b1;
    tick();
    resetEverything = 1'b0;
    tick();
    tick();
    run_op(5, "restart");

    // Randomized ops, back to back (each also checks stale finishedOp)
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_in[i] = DW'($urandom);
        mem_w[i]  = DW'($urandom);
      end
      model(0);
      case (r % 3)
        0:       thr = exp_acc;
        1:       thr = exp_acc + 1;
        default: thr = longint'($urandom_range(200000)) - 100000;
      endcase
      run_op(thr, "rand");
    end

    // Asynchronous reset between edges, mid-fetch
    resetEverything = 1'b1;
    tick();
    resetEverything = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rd", memRdEn, 0);
    chk("arst_addr", memAddr, 0);
    chk("arst_out", neuronOut, 0);
    chk("arst_spike", spike, 0);
    chk("arst_fin", finishedOp, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle_outputs("arst_after");
    end
    $display("op async_reset: outputs cleared mid-fetch");

    run_op(-7, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_neuron_worker.md
Name: mod_neuron_worker

Overview:
- Responder side of the operation handshake driven by the control FSM. It consumes resetEverything/critical and produces finishedOp.
- On each operation it fetches NUM_INPUTS (input, weight) pairs from synapse memory and accumulates their signed products. It then applies a threshold and shift, and raises finishedOp once the result registers are valid.
- Sits between the control FSM and the synapse RAM; one instance per neuron lane.

Parameters:
- NUM_INPUTS, 16, synapses per operation (>=1)
- DATA_W, 8, signed width of input and weight samples
- ADDR_W, 4, synapse address width; must satisfy 2**ADDR_W >= NUM_INPUTS
- SHIFT, 4, arithmetic right shift applied to accumulator before output saturation
- ACC_W, 2*DATA_W+ADDR_W, accumulator width, sized so no overflow is possible

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- resetEverything  in  1  one-cycle clear/start pulse from control FSM
- critical  in  1  operation window; high while the control FSM is in its operation stages
- thresholdIn  in  ACC_W  signed firing threshold, sampled on resetEverything
- memRdEn  out  1  synapse read strobe
- memAddr  out  ADDR_W  synapse address
- inputData  in  DATA_W  signed input sample, valid the cycle after memRdEn
- weightData  in  DATA_W  signed weight, valid the cycle after memRdEn
- neuronOut  out  DATA_W  signed saturated result
- spike  out  1  1 when accumulator >= threshold
- finishedOp  out  1  level; operation result valid

Behaviour:
- Reset (rst_n=0, async): state=IDLE; memRdEn=0, memAddr=0, neuronOut=0, spike=0, finishedOp=0; accumulator and threshold register cleared.
- States: IDLE, FETCH, DRAIN, RESULT, DONE.
- resetEverything=1 in any state, including mid-operation:
  - next cycle state=FETCH
  - acc=0, memAddr=0, finishedOp=0, spike/neuronOut cleared
  - threshold latched from thresholdIn
  - any in-flight read data is discarded
  - resetEverything has priority over every other event.
- FETCH:
  - memRdEn=1 with memAddr=0..NUM_INPUTS-1 in consecutive cycles.
  - After NUM_INPUTS-1 is issued, go to DRAIN.
- Accumulate: in each cycle following a cycle with memRdEn=1, acc += sext(inputData)*sext(weightData). Multiplication is full-precision signed 2*DATA_W.
- DRAIN: one cycle absorbing the final read data, then RESULT.
- RESULT (one cycle), registering:
  - spike = (acc >= threshold), signed compare
  - neuronOut = acc >>> SHIFT, saturated to [-2**(DATA_W-1), 2**(DATA_W-1)-1]
  - then state=DONE.
- DONE: finishedOp=1, held until the next resetEverything or until critical=0. Outputs hold while in DONE.
- Timing: with resetEverything in cycle 0, memRdEn is high in cycles 1..N, RESULT occurs in cycle N+2, and finishedOp is first high in cycle N+3 (N=NUM_INPUTS).
- critical=0 while in FETCH/DRAIN/RESULT: abort to IDLE.
  - memRdEn=0, finishedOp stays 0
  - acc, neuronOut and spike keep their current values until the next resetEverything.
- critical=0 in DONE: go to IDLE; finishedOp drops next cycle; neuronOut/spike hold.
- IDLE ignores memory data. memRdEn is never high outside FETCH.
- N=1: FETCH lasts exactly one cycle.
- finishedOp is deliberately a level. The control FSM samples it in its wait stage. Clearing on resetEverything guarantees a stale finishedOp can never short-circuit the next operation.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=3'd0, FETCH=3'd1, DRAIN=3'd2, RESULT=3'd3, DONE=3'd4
  - saturation bound constants derived from DATA_W
- One natural sub-module: mod_mac_sat. It is a signed multiply-accumulate with clear, plus the shift/saturate output stage, parameterised by DATA_W, ACC_W and SHIFT. The parent holds the FSM and address counter.

Test Plan:
- Basic op: NUM_INPUTS=4, inputs {1,2,3,4}, weights {1,1,1,1}, threshold=10, SHIFT=0; pulse resetEverything, hold critical -> memRdEn cycles 1-4 with addr 0..3, finishedOp rises cycle 7, neuronOut=10, spike=1.
- Negative/saturation: inputs {-128}x4, weights {127}x4, SHIFT=4, threshold=0 -> acc=-65024, neuronOut=-128 (saturated), spike=0.
- Abort mid-fetch: drop critical at cycle 2 -> memRdEn low next cycle, state IDLE, finishedOp stays 0 indefinitely.
- Restart mid-operation: second resetEverything at cycle 3 with threshold=5 -> acc cleared, addr restarts at 0, result reflects only the post-restart fetch, finishedOp cycle N+3 after the second pulse.
- Stale-flag check: complete op (finishedOp=1), keep critical high, pulse resetEverything -> finishedOp 0 in the cycle after the pulse and through the whole new op.
- Async reset: assert rst_n=0 mid-FETCH between clock edges -> all outputs 0 immediately, no memRdEn after release until resetEverything.
